camera_pixel_capture: RTL and testbench

//  Upstream stage of the pixel filters: converts the camera's byte-serial RGB444 stream
//  (vsync/href/8-bit data, two bytes per pixel) into 12-bit {R,G,B} pixels.

---
 rtl/camera_pixel_capture.sv | 145 ++++++++++++++
 tb/tb_camera_pixel_capture.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/camera_pixel_capture.sv
// Byte-serial RGB444 camera capture: vsync/href/8-bit bytes -> 12-bit {R,G,B} pixels with linear address.
// Optional build macro TEST_PATTERN_EN replaces pixel_data with eight vertical colour bars derived from x.
//
//   state      | meaning
//   WAIT_FRAME | after reset, discarding the partial frame until vsync goes high
//   SYNC       | vertical blanking, counters held clear
//   ACTIVE     | frame in progress, bytes captured while href is high
module camera_pixel_capture #(
   parameter int H_RES  = 320,
   parameter int V_RES  = 240,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        cam_data,
   output logic [11:0]       pixel_data,
   output logic              pixel_valid,
   output logic [ADDR_W-1:0] pixel_addr,
   output logic              frame_done,
   output logic              overflow
);

   localparam int TOTAL = H_RES * V_RES;
   localparam int XW    = $clog2(H_RES + 1);
   localparam int BW    = ADDR_W + 1;
   localparam logic [XW-1:0] X_MAX   = XW'(H_RES);
   localparam logic [BW-1:0] B_TOTAL = BW'(TOTAL);
   localparam logic [BW-1:0] B_STEP  = BW'(H_RES);

   typedef enum logic [1:0] {WAIT_FRAME, SYNC, ACTIVE} state_t;

   state_t         state, state_nxt;
   logic           phase;
   logic           href_d;
   logic [3:0]     r_lat;
   logic [XW-1:0]  x;
   logic [BW-1:0]  line_base;   // y*H_RES, saturates at H_RES*V_RES
   logic           in_line;
   logic           in_frame;
   logic [11:0]    pix_word;

   always_ff @(posedge clk) begin
      if (reset) state <= WAIT_FRAME;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_FRAME: if (vsync)  state_nxt = SYNC;
         SYNC:       if (!vsync) state_nxt = ACTIVE;
         ACTIVE:     if (vsync)  state_nxt = SYNC;
         default:                state_nxt = WAIT_FRAME;
      endcase
   end

   assign in_line  = (x < X_MAX);
   assign in_frame = (line_base < B_TOTAL);

`ifdef TEST_PATTERN_EN
   logic [2:0] bar;
   assign bar = 3'((32'(x) * 32'd8) / 32'(H_RES));
   always_comb begin
      pix_word = 12'h000;
      case (bar)
         3'd0: pix_word = 12'hFFF;
         3'd1: pix_word = 12'hFF0;
         3'd2: pix_word = 12'h0FF;
         3'd3: pix_word = 12'h0F0;
         3'd4: pix_word = 12'hF0F;
         3'd5: pix_word = 12'hF00;
         3'd6: pix_word = 12'h00F;
         default: pix_word = 12'h000;
      endcase
   end
`else
   assign pix_word = {r_lat, cam_data};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         phase       <= 1'b0;
         href_d      <= 1'b0;
         r_lat       <= 4'h0;
         x           <= '0;
         line_base   <= '0;
         pixel_data  <= 12'h000;
         pixel_valid <= 1'b0;
         pixel_addr  <= '0;
         frame_done  <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         case (state)
            WAIT_FRAME, SYNC: begin
               phase     <= 1'b0;
               href_d    <= 1'b0;
               x         <= '0;
               line_base <= '0;
               if (state == SYNC && !vsync) overflow <= 1'b0;
            end
            ACTIVE: begin
               if (vsync) begin
                  // frame ends (possibly mid-line); blanking clears the counters
                  frame_done <= 1'b1;
                  phase      <= 1'b0;
                  href_d     <= 1'b0;
                  x          <= '0;
                  line_base  <= '0;
               end else begin
                  href_d <= href;
                  if (href) begin
                     phase <= ~phase;
                     if (!phase) begin
                        r_lat <= cam_data[3:0];
                     end else if (in_line) begin
                        x <= x + XW'(1);
                        if (in_frame) begin
                           pixel_valid <= 1'b1;
                           pixel_data  <= pix_word;
                           pixel_addr  <= ADDR_W'(line_base + BW'(x));
                        end else begin
                           overflow <= 1'b1;
                        end
                     end
                  end else if (href_d) begin
                     // line end: a pending half pixel is simply dropped
                     phase <= 1'b0;
                     x     <= '0;
                     if (in_frame) line_base <= line_base + B_STEP;
                  end
               end
            end
            default: begin
               phase  <= 1'b0;
               href_d <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_camera_pixel_capture.sv
// Directed bench for camera_pixel_capture using a reduced 16x4 frame so a full frame stays short.
// Expected pixel data follows the TEST_PATTERN_EN bar table when that macro is defined.
module tb_camera_pixel_capture;

   localparam int H  = 16;
   localparam int V  = 4;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          vsync;
   logic          href;
   logic [7:0]    cam_data;
   logic [11:0]   pixel_data;
   logic          pixel_valid;
   logic [AW-1:0] pixel_addr;
   logic          frame_done;
   logic          overflow;

   int n_chk = 0;
   int n_err = 0;

   camera_pixel_capture #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .vsync(vsync), .href(href), .cam_data(cam_data),
      .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_addr(pixel_addr),
      .frame_done(frame_done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] exp_data(input int x, input logic [11:0] d);
`ifdef TEST_PATTERN_EN
      logic [11:0] bars [8];
      bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
      return bars[(x * 8) / H];
`else
      return d;
`endif
   endfunction

   function automatic logic [11:0] frame_word(input int a);
      return 12'(a * 53) ^ 12'h5A5;
   endfunction

   // two bytes of one pixel; leaves href high so pixels can be sent back to back
   task automatic pix(input logic [11:0] d, input int x, input logic ev, input int ea);
      href     = 1'b1;
      cam_data = {4'h0, d[11:8]};
      tick();
      chk("valid_after_byte0", pixel_valid, 1'b0);
      cam_data = d[7:0];
      tick();
      chk("valid", pixel_valid, ev);
      if (ev) begin
         chk("data", pixel_data, exp_data(x, d));
         chk("addr", pixel_addr, ea);
      end
   endtask

   initial begin
      reset = 1'b1; vsync = 1'b0; href = 1'b0; cam_data = 8'h00;
      tick();
      tick();
      chk("rst_valid", pixel_valid, 1'b0);
      chk("rst_data", pixel_data, 12'h000);
      chk("rst_addr", pixel_addr, 0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      reset = 1'b0;

      // bytes before the first vsync high->low are discarded
      pix(12'h123, 0, 1'b0, 0);
      pix(12'h456, 1, 1'b0, 0);
      href = 1'b0;
      tick();

      vsync = 1'b1; tick();
      vsync = 1'b0; tick();
      pix(12'hABC, 0, 1'b1, 0);
      href = 1'b0;
      tick();
      chk("single_strobe", pixel_valid, 1'b0);
      chk("data_hold", pixel_data, exp_data(0, 12'hABC));

      // line 1 ends on an odd byte
      pix(12'h111, 0, 1'b1, 16);
      pix(12'h222, 1, 1'b1, 17);
      pix(12'h333, 2, 1'b1, 18);
      cam_data = 8'h05; href = 1'b1;
      tick();
      chk("half_pixel_byte", pixel_valid, 1'b0);
      href = 1'b0;
      tick();
      chk("half_pixel_drop", pixel_valid, 1'b0);
      pix(12'h5E7, 0, 1'b1, 32);
      href = 1'b0;
      tick();

      vsync = 1'b1;
      tick();
      chk("frame_done_pulse", frame_done, 1'b1);
      tick();
      chk("frame_done_single", frame_done, 1'b0);
      chk("valid_in_sync", pixel_valid, 1'b0);

      // full frame, with one surplus pixel on the first line
      vsync = 1'b0;
      tick();
      chk("ovf_clear_start", overflow, 1'b0);
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) pix(frame_word(y * H + x), x, 1'b1, y * H + x);
         if (y == 0) pix(12'hEEE, H, 1'b0, 0);
         href = 1'b0;
         tick();
         chk("line_gap_valid", pixel_valid, 1'b0);
      end
      chk("frame_ovf_none", overflow, 1'b0);
      chk("frame_last_addr", pixel_addr, H * V - 1);

      // four pixels beyond the frame
      for (int x = 0; x < 4; x++) pix(12'h0F0 + 12'(x), x, 1'b0, 0);
      chk("ovf_set", overflow, 1'b1);
      chk("ovf_addr_hold", pixel_addr, H * V - 1);
      chk("ovf_data_hold", pixel_data, exp_data(H - 1, frame_word(H * V - 1)));
      href = 1'b0;
      tick();
      vsync = 1'b1;
      tick();
      chk("frame_done_end", frame_done, 1'b1);
      chk("ovf_sticky_edge", overflow, 1'b1);
      tick();
      chk("ovf_sticky_sync", overflow, 1'b1);
      vsync = 1'b0;
      tick();
      chk("ovf_cleared", overflow, 1'b0);

      // reset in the middle of a pixel
      pix(12'h321, 0, 1'b1, 0);
      cam_data = 8'h0F;
      tick();
      reset = 1'b1; cam_data = 8'h77;
      tick();
      chk("midrst_valid", pixel_valid, 1'b0);
      chk("midrst_data", pixel_data, 12'h000);
      chk("midrst_addr", pixel_addr, 0);
      chk("midrst_frame_done", frame_done, 1'b0);
      chk("midrst_overflow", overflow, 1'b0);
      reset = 1'b0; href = 1'b0;
      tick();
      pix(12'h999, 0, 1'b0, 0);
      href = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
